fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: REG_SIZE, default 32, datapath and address width in bits.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset (must be word-aligned).
REQ-003 Parameter: NOP_INST, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 stall_i  input  1  hold PC and IF/DE register.
REQ-008 br_taken_i  input  1  redirect request from execute (branch/jump taken).
REQ-009 br_target_i  input  REG_SIZE  redirect byte address.
REQ-010 inst_i  input  REG_SIZE  instruction word returned combinationally by instruction memory for pc_o.
REQ-011 pc_o  output  REG_SIZE  current fetch PC, drives instruction memory byte address.
REQ-012 pc_d_o  output  REG_SIZE  IF/DE register: PC of delivered instruction.
REQ-013 inst_d_o  output  REG_SIZE  IF/DE register: delivered instruction.
REQ-014 valid_d_o  output  1  IF/DE register holds a real instruction.
REQ-015 misalign_o  output  1  one-cycle flag: last redirect target had nonzero bits [1:0].
REQ-016 fetch_cnt_o  output  32  count of valid instructions loaded into IF/DE.

Function
REQ-017 pc_o SHALL be driven directly from the PC register, no combinational path from any input.
REQ-018 Normal cycle (br_taken_i=0, stall_i=0): PC <= PC+4 modulo 2^REG_SIZE; pc_d_o <= pc_o; inst_d_o <= inst_i; valid_d_o <= 1.
REQ-019 Latency: the word at address A SHALL appear on inst_d_o exactly one rising edge after pc_o=A in a non-stalled, non-redirected cycle.
REQ-020 Stall (stall_i=1, br_taken_i=0): PC, pc_d_o, inst_d_o, valid_d_o SHALL hold; fetch_cnt_o SHALL hold.
REQ-021 Redirect (br_taken_i=1): PC <= {br_target_i[REG_SIZE-1:2], 2'b00}; inst_d_o <= NOP_INST; pc_d_o <= 0; valid_d_o <= 0.
REQ-022 Redirect SHALL take priority over stall when both are asserted in the same cycle.
REQ-023 misalign_o SHALL be registered: set to |br_target_i[1:0] on a redirect edge, 0 on every other edge.
REQ-024 fetch_cnt_o SHALL increment by 1 on each edge where valid_d_o is loaded with 1 (REQ-018), wrapping 32'hFFFF_FFFF -> 0.
REQ-025 PC wrap: PC=32'hFFFF_FFFC non-stalled SHALL advance to 32'h0000_0000 with no flag.
REQ-026 Back-to-back redirects SHALL each be honoured; the IF/DE register stays invalid until the first non-redirect, non-stall edge.

Reset
REQ-027 While rst_n=0, asynchronously: PC=RESET_PC, pc_d_o=0, inst_d_o=NOP_INST, valid_d_o=0, misalign_o=0, fetch_cnt_o=0.
REQ-028 First edge after rst_n deassertion SHALL behave per REQ-018/020/021 with no extra bubble.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL override both immediately and discard the pending target.

Verification
REQ-030 Reset release, stall_i=0, memory word i = 32'h1000_0000+i for 4 edges -> pc_o 0,4,8,C,10; inst_d_o NOP,1000_0000,1000_0001,1000_0002,1000_0003; fetch_cnt_o=4.
REQ-031 Stall 3 cycles at pc_o=8 -> pc_o stays 8, inst_d_o/pc_d_o frozen, fetch_cnt_o unchanged; resumes with pc_d_o=8 next edge.
REQ-032 br_taken_i=1, stall_i=1, br_target_i=32'h0000_0102 -> next pc_o=32'h0000_0100, valid_d_o=0, inst_d_o=NOP_INST, misalign_o=1 for exactly one cycle.
REQ-033 PC preloaded to 32'hFFFF_FFFC by redirect, no stall -> next pc_o=0, pc_d_o=32'hFFFF_FFFC, valid_d_o=1.
REQ-034 rst_n pulsed low between edges during a redirect -> all outputs at reset values before next edge, pc_o=RESET_PC afterwards.
REQ-035 Two consecutive redirects to 0x40 then 0x80 -> pc_o 0x40 then 0x80, valid_d_o=0 both cycles, then inst from 0x80 delivered with valid_d_o=1.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/DE pipeline register, redirect/stall
// handling, misaligned-target flag and delivered-instruction counter.
module fetch_stage #(
  parameter int unsigned            REG_SIZE = 32,
  parameter logic [REG_SIZE-1:0]    RESET_PC = '0,
  parameter logic [REG_SIZE-1:0]    NOP_INST = 'h13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                br_taken_i,
  input  logic [REG_SIZE-1:0] br_target_i,
  input  logic [REG_SIZE-1:0] inst_i,
  output logic [REG_SIZE-1:0] pc_o,
  output logic [REG_SIZE-1:0] pc_d_o,
  output logic [REG_SIZE-1:0] inst_d_o,
  output logic                valid_d_o,
  output logic                misalign_o,
  output logic [31:0]         fetch_cnt_o
);

  logic [REG_SIZE-1:0] r_pc;
  logic [REG_SIZE-1:0] r_pc_d;
  logic [REG_SIZE-1:0] r_inst_d;
  logic                r_valid_d;
  logic                r_misalign;
  logic [31:0]         r_fetch_cnt;

  logic [REG_SIZE-1:0] w_pc_inc;
  logic [REG_SIZE-1:0] w_target_aligned;

  assign w_pc_inc         = r_pc + {{(REG_SIZE-3){1'b0}}, 3'b100};
  assign w_target_aligned = {br_target_i[REG_SIZE-1:2], 2'b00};

  // Redirect is tested first so it wins over a simultaneous stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_pc_d      <= '0;
      r_inst_d    <= NOP_INST;
      r_valid_d   <= 1'b0;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (br_taken_i) begin
        r_pc       <= w_target_aligned;
        r_pc_d     <= '0;
        r_inst_d   <= NOP_INST;
        r_valid_d  <= 1'b0;
        r_misalign <= |br_target_i[1:0];
      end else if (!stall_i) begin
        r_pc        <= w_pc_inc;
        r_pc_d      <= r_pc;
        r_inst_d    <= inst_i;
        r_valid_d   <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign pc_o        = r_pc;
  assign pc_d_o      = r_pc_d;
  assign inst_d_o    = r_inst_d;
  assign valid_d_o   = r_valid_d;
  assign misalign_o  = r_misalign;
  assign fetch_cnt_o = r_fetch_cnt;

endmodule
